// File: rtl/spi_reg_access_ctrl_if.sv
// Bundle between the SPI slave byte driver, the frame controller and the register file.
// master: the frame controller; slave: the driver/register-file side.
interface spi_reg_access_ctrl_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              cs_n;
  logic [7:0]        rec_data;
  logic              rec_valid;
  logic [7:0]        response_data;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [7:0]        reg_rdata;
  logic              busy;
  logic              frame_err;

  modport master (
    input  cs_n, rec_data, rec_valid, reg_rdata,
    output response_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy, frame_err
  );

  modport slave (
    output cs_n, rec_data, rec_valid, reg_rdata,
    input  response_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy, frame_err
  );
endinterface

// File: rtl/spi_reg_access_ctrl.sv
// Frame-level controller behind the SPI slave byte driver: decodes {cmd, data...}
// into single-cycle register reads/writes and supplies the next MISO byte.
// Optional feature: define SPI_REG_BURST_EN for auto-increment burst access
// (frames then end only on cs_n rising).
module spi_reg_access_ctrl #(
  parameter int unsigned ADDR_W      = 7,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_reg_access_ctrl_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] WDATA  = 3'd2;
  localparam logic [2:0] RD_REQ = 3'd3;
  localparam logic [2:0] RD_CAP = 3'd4;
  localparam logic [2:0] RDATA  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  // Command bits above the address field that must be zero.
  localparam logic [6:0] HI_MASK = ~7'((8'd1 << ADDR_W) - 8'd1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        response_q, response_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_wr_en_q, reg_wr_en_d;
  logic              reg_rd_en_q, reg_rd_en_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;

  logic              live_byte_c;
  logic              cmd_illegal_c;

  // A byte only starts new work while the frame is still selected; a data byte
  // in WDATA is honored even when cs_n rises in the same cycle.
  assign live_byte_c   = bus.rec_valid & ~bus.cs_n;
  assign cmd_illegal_c = |(bus.rec_data[6:0] & HI_MASK);

  // Next-state, strobe and response decode.
  always_comb begin
    state_d     = state_q;
    response_d  = response_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_en_d = 1'b0;
    reg_rd_en_d = 1'b0;
    frame_err_d = 1'b0;

`ifdef SPI_REG_BURST_EN
    // Advance to the next burst address once the write strobe has been seen.
    if (reg_wr_en_q) begin
      reg_addr_d = reg_addr_q + ADDR_W'(1);
    end
`endif

    case (state_q)
      IDLE: begin
        if (!bus.cs_n) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (live_byte_c) begin
          if (cmd_illegal_c) begin
            frame_err_d = 1'b1;
            response_d  = FILL_BYTE;
            state_d     = DONE;
          end else begin
            reg_addr_d = bus.rec_data[ADDR_W-1:0];
            if (bus.rec_data[7]) begin
              reg_rd_en_d = 1'b1;
              state_d     = RD_REQ;
            end else begin
              response_d = FILL_BYTE;
              state_d    = WDATA;
            end
          end
        end
      end
      RD_REQ: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        response_d = bus.reg_rdata;
        state_d    = RDATA;
      end
      WDATA: begin
        if (bus.rec_valid) begin
          reg_wdata_d = bus.rec_data;
          reg_wr_en_d = 1'b1;
`ifdef SPI_REG_BURST_EN
          state_d     = WDATA;
`else
          state_d     = DONE;
`endif
        end
      end
      RDATA: begin
        if (live_byte_c) begin
`ifdef SPI_REG_BURST_EN
          reg_addr_d  = reg_addr_q + ADDR_W'(1);
          reg_rd_en_d = 1'b1;
          state_d     = RD_REQ;
`else
          response_d  = FILL_BYTE;
          state_d     = DONE;
`endif
        end
      end
      DONE: begin
        response_d = FILL_BYTE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Deselect ends the frame from any state; a read still in flight is dropped.
    if (bus.cs_n) begin
      state_d    = IDLE;
      response_d = STATUS_BYTE;
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      response_q  <= STATUS_BYTE;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'h00;
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      response_q  <= response_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_rd_en_q <= reg_rd_en_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.response_data = response_q;
  assign bus.reg_addr      = reg_addr_q;
  assign bus.reg_wdata     = reg_wdata_q;
  assign bus.reg_wr_en     = reg_wr_en_q;
  assign bus.reg_rd_en     = reg_rd_en_q;
  assign bus.busy          = busy_q;
  assign bus.frame_err     = frame_err_q;

endmodule

// File: tb/tb_spi_reg_access_ctrl.sv
// Bench for spi_reg_access_ctrl (ADDR_W=4): directed frames then random frames,
// checked against a frame-level model of MISO bytes and register-bus accesses.
module tb_spi_reg_access_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam logic [7:0]  STATUS = 8'hA5;
  localparam logic [7:0]  FILL   = 8'h00;
  localparam int          GAP    = 12;
`ifdef SPI_REG_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic       lat_ok;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  spi_reg_access_ctrl #(
    .ADDR_W     (ADDR_W),
    .STATUS_BYTE(STATUS),
    .FILL_BYTE  (FILL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] model_mem [16];
  logic [7:0] tb_mem    [16];
  logic       init_mem   = 1'b0;
  logic       prev_rv    = 1'b0;
  int         err_pulses = 0;
  int         both_hi    = 0;
  op_t        obs_q [$];
  logic [7:0] frm   [$];

  // Register file and bus monitor: serves reads one clock after the strobe.
  always @(posedge clk) begin
    prev_rv <= bus.rec_valid;
    if (init_mem) begin
      for (int k = 0; k < 16; k++) tb_mem[k] <= model_mem[k];
    end
    if (bus.frame_err) err_pulses <= err_pulses + 1;
    if (bus.reg_wr_en && bus.reg_rd_en) both_hi <= both_hi + 1;
    if (bus.reg_wr_en) begin
      tb_mem[bus.reg_addr] <= bus.reg_wdata;
      obs_q.push_back({1'b1, bus.reg_addr, bus.reg_wdata, prev_rv});
    end
    if (bus.reg_rd_en) begin
      bus.reg_rdata <= tb_mem[bus.reg_addr];
      obs_q.push_back({1'b0, bus.reg_addr, tb_mem[bus.reg_addr], prev_rv});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs the frame held in frm. The last byte coincides with cs_n rising unless
  // abort is set, in which case cs_n rises later with no further byte.
  task automatic run_frame(input string tag, input bit abort);
    logic [7:0] miso [$];
    op_t        ops  [$];
    op_t        o;
    bit         exp_err;
    int         n, last, base, e0, m;
    logic [7:0] cmd;
    logic [3:0] a;

    n       = frm.size();
    last    = abort ? n : n - 1;
    cmd     = frm[0];
    exp_err = 1'b0;
    miso.push_back(STATUS);
    if (cmd[6:4] != 3'b000) begin
      exp_err = 1'b1;
      for (int i = 1; i <= n; i++) miso.push_back(FILL);
    end else if (!cmd[7]) begin
      for (int i = 1; i <= n; i++) miso.push_back(FILL);
      for (int i = 1; i < n; i++) begin
        if (BURST || i == 1) begin
          a = cmd[3:0] + 4'(i - 1);
          o.wr = 1'b1; o.addr = a; o.data = frm[i]; o.lat_ok = 1'b1;
          ops.push_back(o);
          model_mem[a] = frm[i];
        end
      end
    end else begin
      for (int i = 1; i <= n; i++) begin
        if (BURST || i == 1) begin
          a = cmd[3:0] + 4'(i - 1);
          miso.push_back(model_mem[a]);
          if (i <= last) begin
            o.wr = 1'b0; o.addr = a; o.data = model_mem[a]; o.lat_ok = 1'b1;
            ops.push_back(o);
          end
        end else begin
          miso.push_back(FILL);
        end
      end
    end

    base = obs_q.size();
    e0   = err_pulses;
    bus.cs_n = 1'b0;
    tick(); tick(); tick();
    check({tag, " busy_in_frame"}, 32'(bus.busy), 32'd1);
    check({tag, " miso0"}, 32'(bus.response_data), 32'(miso[0]));
    for (int i = 0; i < n; i++) begin
      repeat (GAP) tick();
      bus.rec_data  = frm[i];
      bus.rec_valid = 1'b1;
      if (!abort && i == n - 1) bus.cs_n = 1'b1;
      tick();
      bus.rec_valid = 1'b0;
      bus.rec_data  = 8'($urandom);
      tick(); tick();
      if (!abort && i == n - 1)
        check({tag, " miso_after_end"}, 32'(bus.response_data), 32'(STATUS));
      else
        check({tag, " miso"}, 32'(bus.response_data), 32'(miso[i + 1]));
    end
    if (abort) begin
      repeat (GAP) tick();
      bus.cs_n = 1'b1;
      tick(); tick();
      check({tag, " miso_after_abort"}, 32'(bus.response_data), 32'(STATUS));
    end
    repeat (4) tick();
    check({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, " op_count"}, 32'(obs_q.size() - base), 32'(ops.size()));
    m = (ops.size() < obs_q.size() - base) ? ops.size() : obs_q.size() - base;
    for (int j = 0; j < m; j++)
      check({tag, " op"}, 32'(obs_q[base + j]), 32'(ops[j]));
    check({tag, " frame_err_pulses"}, 32'(err_pulses - e0), exp_err ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [7:0] c;
    int         n;
    bit         ab;

    bus.cs_n      = 1'b1;
    bus.rec_data  = 8'h00;
    bus.rec_valid = 1'b0;
    for (int k = 0; k < 16; k++) model_mem[k] = 8'($urandom);

    repeat (3) tick();
    check("rst response", 32'(bus.response_data), 32'(STATUS));
    check("rst addr",     32'(bus.reg_addr),      32'd0);
    check("rst wdata",    32'(bus.reg_wdata),     32'd0);
    check("rst wr_en",    32'(bus.reg_wr_en),     32'd0);
    check("rst rd_en",    32'(bus.reg_rd_en),     32'd0);
    check("rst busy",     32'(bus.busy),          32'd0);
    check("rst frame_err",32'(bus.frame_err),     32'd0);
    rst_n    = 1'b1;
    init_mem = 1'b1;
    tick();
    init_mem = 1'b0;
    repeat (3) tick();

    frm = '{8'h05, 8'h3C};                 run_frame("t1_write", 1'b0);
    frm = '{8'h05, 8'h77};                 run_frame("t2_prep", 1'b0);
    frm = '{8'h85, 8'h00};                 run_frame("t2_read", 1'b0);
    frm = '{8'h15, 8'h33, 8'h44};          run_frame("t3_illegal", 1'b0);
    frm = '{8'h03};                        run_frame("t4_abort", 1'b1);
    frm = '{8'h03, 8'h5A};                 run_frame("t4_after", 1'b0);
    frm = '{8'h0F, 8'h11, 8'h22};          run_frame("t5_wrap_write", 1'b0);
    frm = '{8'h82, 8'h00, 8'h00, 8'h00};   run_frame("t6_burst_read", 1'b0);
    frm = '{8'h01, 8'hAA, 8'hBB};          run_frame("t7_single", 1'b0);

    repeat (40) begin
      n = $urandom_range(2, 5);
      c = 8'($urandom);
      if ($urandom_range(0, 3) != 0) c[6:4] = 3'b000;
      ab = ($urandom_range(0, 5) == 0);
      frm.delete();
      frm.push_back(c);
      for (int i = 1; i < n; i++) frm.push_back(8'($urandom));
      run_frame("rnd", ab);
    end

    check("strobe_exclusive", 32'(both_hi), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
